// File: rtl/constant_checker_pkg.sv
// Shared definitions for the constant checker: state encoding and a
// constant-evaluable ceiling-log2 used to size the run counter.
package constant_checker_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      ERROR  = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned remaining;
      result    = 0;
      remaining = (value > 0) ? value - 1 : 0;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/constant_checker_counter.sv
// Saturating up-counter used for the match/mismatch statistics; holds at
// all-ones instead of wrapping, and only the synchronous clear zeroes it.
module counter_saturating
   import constant_checker_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  increment,
   output logic [WORD_WIDTH-1:0] count
);

   localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

   logic [WORD_WIDTH-1:0] count_q;
   logic [WORD_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (increment && (count_q != '1)) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/constant_checker.sv
// Constant-stream checker: hunts for LOCK_COUNT consecutive VALUE words, then
// flags and captures the first mismatching word until rearmed or cleared.
module constant_checker
   import constant_checker_pkg::*;
#(
   parameter int unsigned           WORD_WIDTH  = 8,
   parameter logic [WORD_WIDTH-1:0] VALUE       = '0,
   parameter int unsigned           LOCK_COUNT  = 4,
   parameter int unsigned           COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   input  logic [WORD_WIDTH-1:0]  sample_data,
   input  logic                   rearm,
   output logic                   locked,
   output logic                   error,
   output logic [WORD_WIDTH-1:0]  first_bad_word,
   output logic [COUNT_WIDTH-1:0] match_count,
   output logic [COUNT_WIDTH-1:0] mismatch_count
);

   localparam int unsigned          RUN_WIDTH = clog2(LOCK_COUNT + 1);
   localparam logic [RUN_WIDTH-1:0] RUN_ONE   = RUN_WIDTH'(1);
   localparam logic [RUN_WIDTH-1:0] RUN_LOCK  = RUN_WIDTH'(LOCK_COUNT);

   state_t                state_q;
   state_t                state_d;
   logic [RUN_WIDTH-1:0]  run_q;
   logic [RUN_WIDTH-1:0]  run_d;
   logic [RUN_WIDTH-1:0]  run_inc;
   logic [WORD_WIDTH-1:0] bad_q;
   logic [WORD_WIDTH-1:0] bad_d;
   logic                  ready_q;
   logic                  accept;
   logic                  match;

   assign accept  = sample_valid & ready_q;
   assign match   = (sample_data == VALUE);
   // Run count saturates at LOCK_COUNT so it can never overflow its width.
   assign run_inc = (run_q == RUN_LOCK) ? RUN_LOCK : run_q + RUN_ONE;

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= HUNT;
         run_q   <= '0;
         bad_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         bad_q   <= bad_d;
         ready_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      bad_d   = bad_q;
      case (state_q)
         HUNT: begin
            if (accept) begin
               if (match) begin
                  run_d = run_inc;
                  if (run_inc == RUN_LOCK) begin
                     state_d = LOCKED;
                  end
               end else begin
                  run_d = '0;
               end
            end
         end
         LOCKED: begin
            if (accept && !match) begin
               state_d = ERROR;
               run_d   = '0;
               bad_d   = sample_data;
            end
         end
         ERROR: begin
            // A word accepted alongside rearm already counts toward the new run.
            if (rearm) begin
               if (accept && match) begin
                  run_d   = RUN_ONE;
                  state_d = (RUN_ONE == RUN_LOCK) ? LOCKED : HUNT;
               end else begin
                  run_d   = '0;
                  state_d = HUNT;
               end
            end
         end
         default: begin
            state_d = HUNT;
            run_d   = '0;
         end
      endcase
   end

   always_comb begin
      locked = (state_q == LOCKED);
      error  = (state_q == ERROR);
   end

   assign sample_ready   = ready_q;
   assign first_bad_word = bad_q;

   counter_saturating #(
      .WORD_WIDTH(COUNT_WIDTH)
   ) u_match_count (
      .clock    (clock),
      .clear    (clear),
      .increment(accept & match),
      .count    (match_count)
   );

   counter_saturating #(
      .WORD_WIDTH(COUNT_WIDTH)
   ) u_mismatch_count (
      .clock    (clock),
      .clear    (clear),
      .increment(accept & ~match),
      .count    (mismatch_count)
   );

endmodule

// File: tb/tb_constant_checker.sv
// Bench for constant_checker: two instances (LOCK_COUNT=4/16-bit counters and
// LOCK_COUNT=1/3-bit counters) share stimulus and are compared to a rule model.
module tb_constant_checker;

   logic       clock = 1'b0;
   logic       clear;
   logic       sample_valid;
   logic       rearm;
   logic [7:0] sample_data;

   logic [1:0]  o_ready;
   logic [1:0]  o_locked;
   logic [1:0]  o_error;
   logic [7:0]  a_bad;
   logic [7:0]  b_bad;
   logic [15:0] a_mc;
   logic [15:0] a_mmc;
   logic [2:0]  b_mc;
   logic [2:0]  b_mmc;

   int checks = 0;
   int errors = 0;

   // Reference model state, one entry per instance.
   int unsigned m_lock_count [2] = '{4, 1};
   int unsigned m_cmax       [2] = '{65535, 7};
   bit          m_ready;
   bit          m_locked  [2];
   bit          m_error   [2];
   int unsigned m_run     [2];
   int unsigned m_matches [2];
   int unsigned m_mism    [2];
   logic [7:0]  m_bad     [2];

   always #5 clock = ~clock;

   constant_checker #(
      .WORD_WIDTH(8), .VALUE(8'hA5), .LOCK_COUNT(4), .COUNT_WIDTH(16)
   ) dut_a (
      .clock(clock), .clear(clear), .sample_valid(sample_valid),
      .sample_ready(o_ready[0]), .sample_data(sample_data), .rearm(rearm),
      .locked(o_locked[0]), .error(o_error[0]), .first_bad_word(a_bad),
      .match_count(a_mc), .mismatch_count(a_mmc)
   );

   constant_checker #(
      .WORD_WIDTH(8), .VALUE(8'hA5), .LOCK_COUNT(1), .COUNT_WIDTH(3)
   ) dut_b (
      .clock(clock), .clear(clear), .sample_valid(sample_valid),
      .sample_ready(o_ready[1]), .sample_data(sample_data), .rearm(rearm),
      .locked(o_locked[1]), .error(o_error[1]), .first_bad_word(b_bad),
      .match_count(b_mc), .mismatch_count(b_mmc)
   );

   function automatic logic [7:0] got_bad(input int k);
      return (k == 0) ? a_bad : b_bad;
   endfunction

   function automatic logic [15:0] got_mc(input int k);
      return (k == 0) ? a_mc : {13'd0, b_mc};
   endfunction

   function automatic logic [15:0] got_mmc(input int k);
      return (k == 0) ? a_mmc : {13'd0, b_mmc};
   endfunction

   function automatic logic [15:0] exp_count(input int unsigned total, input int unsigned cmax);
      return 16'((total > cmax) ? cmax : total);
   endfunction

   // Applies the behavioural rules for one rising edge using the current inputs.
   task automatic model_edge();
      bit acc;
      bit mt;
      if (clear) begin
         m_ready = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_locked[k] = 1'b0; m_error[k] = 1'b0; m_run[k] = 0;
            m_matches[k] = 0; m_mism[k] = 0; m_bad[k] = 8'h00;
         end
         return;
      end
      acc = sample_valid && m_ready;
      mt  = (sample_data == 8'hA5);
      for (int k = 0; k < 2; k++) begin
         if (acc) begin
            if (mt) m_matches[k]++;
            else    m_mism[k]++;
         end
         if (m_error[k]) begin
            if (rearm) begin
               m_error[k]  = 1'b0;
               m_run[k]    = (acc && mt) ? 1 : 0;
               m_locked[k] = (m_run[k] >= m_lock_count[k]);
            end
         end else if (m_locked[k]) begin
            if (acc && !mt) begin
               m_locked[k] = 1'b0;
               m_error[k]  = 1'b1;
               m_bad[k]    = sample_data;
            end
         end else if (acc) begin
            m_run[k] = mt ? m_run[k] + 1 : 0;
            if (m_run[k] == m_lock_count[k]) m_locked[k] = 1'b1;
         end
      end
      m_ready = 1'b1;
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
      sample_valid = v;
      sample_data  = d;
      rearm        = r;
      clear        = c;
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hA5, 1'b0, 1'b1);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ready[k] !== 1'b0 || o_locked[k] !== 1'b0 || o_error[k] !== 1'b0 ||
                got_bad(k) !== 8'h00 || got_mc(k) !== 16'd0 || got_mmc(k) !== 16'd0) begin
               errors++;
               $display("FAIL reset[%0d] got rdy=%b lck=%b err=%b bad=%h mc=%0d mmc=%0d exp all 0",
                        k, o_ready[k], o_locked[k], o_error[k], got_bad(k), got_mc(k), got_mmc(k));
            end
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (o_ready !== 2'b11) begin
         errors++;
         $display("FAIL ready_after_clear got %b exp 11", o_ready);
      end
   endtask

   task automatic test_lock();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'hA5, 1'b0, 1'b0);
         checks++;
         if (o_locked !== {1'b1, 1'(i == 3)}) begin
            errors++;
            $display("FAIL lock_run word %0d got %b exp %b", i, o_locked, {1'b1, 1'(i == 3)});
         end
      end
      checks++;
      if (a_mc !== 16'd4) begin
         errors++;
         $display("FAIL lock_match_count got %0d exp 4", a_mc);
      end
      do_clear();
      begin
         logic [7:0] seq [7] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
         for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq[i], 1'b0, 1'b0);
            checks++;
            if (o_locked[0] !== 1'(i == 6)) begin
               errors++;
               $display("FAIL broken_run word %0d got %b exp %b", i, o_locked[0], 1'(i == 6));
            end
         end
      end
      checks++;
      if (a_mmc !== 16'd1 || o_error[0] !== 1'b0 || a_mc !== 16'd6) begin
         errors++;
         $display("FAIL broken_run_stats got mmc=%0d err=%b mc=%0d exp 1 0 6", a_mmc, o_error[0], a_mc);
      end
      checks++;
      if (o_error[1] !== m_error[1] || b_bad !== m_bad[1] || o_locked[1] !== m_locked[1]) begin
         errors++;
         $display("FAIL lock1_error got err=%b bad=%h lck=%b exp %b %h %b",
                  o_error[1], b_bad, o_locked[1], m_error[1], m_bad[1], m_locked[1]);
      end
   endtask

   task automatic test_error_capture();
      do_clear();
      for (int i = 0; i < 4; i++) drive(1'b1, 8'hA5, 1'b0, 1'b0);
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_error[k] !== 1'b1 || o_locked[k] !== 1'b0 || got_bad(k) !== 8'h3C || got_mmc(k) !== 16'd2) begin
            errors++;
            $display("FAIL error_capture[%0d] got err=%b lck=%b bad=%h mmc=%0d exp 1 0 3c 2",
                     k, o_error[k], o_locked[k], got_bad(k), got_mmc(k));
         end
      end
   endtask

   task automatic test_rearm();
      drive(1'b1, 8'hA5, 1'b1, 1'b0);
      checks++;
      if (o_error !== 2'b00 || o_locked !== 2'b10 || a_bad !== 8'h3C || b_bad !== 8'h3C) begin
         errors++;
         $display("FAIL rearm_match got err=%b lck=%b bad=%h/%h exp 00 10 3c/3c", o_error, o_locked, a_bad, b_bad);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hA5, 1'b0, 1'b0);
         checks++;
         if (o_locked[0] !== 1'(i == 2)) begin
            errors++;
            $display("FAIL rearm_relock word %0d got %b exp %b", i, o_locked[0], 1'(i == 2));
         end
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (o_locked !== 2'b11 || o_error !== 2'b00 || a_bad !== 8'h3C) begin
         errors++;
         $display("FAIL rearm_while_locked got lck=%b err=%b bad=%h exp 11 00 3c", o_locked, o_error, a_bad);
      end
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 8'h22, 1'b1, 1'b0);
      checks++;
      if (o_error !== 2'b00 || o_locked !== 2'b00 || a_bad !== 8'h11 || b_bad !== 8'h11) begin
         errors++;
         $display("FAIL rearm_mismatch got err=%b lck=%b bad=%h/%h exp 00 00 11/11", o_error, o_locked, a_bad, b_bad);
      end
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++;
      if (o_locked !== 2'b10) begin
         errors++;
         $display("FAIL rearm_run_zero got %b exp 10", o_locked);
      end
   endtask

   task automatic test_saturation();
      do_clear();
      for (int n = 1; n <= 10; n++) begin
         drive(1'b1, 8'hA5, 1'b0, 1'b0);
         checks++;
         if (a_mc !== 16'(n) || b_mc !== 3'((n > 7) ? 7 : n)) begin
            errors++;
            $display("FAIL saturate n=%0d got %0d/%0d exp %0d/%0d", n, a_mc, b_mc, n, (n > 7) ? 7 : n);
         end
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 8'($urandom), 1'b0, 1'b0);
         checks++;
         if (a_mc !== 16'd10 || b_mc !== 3'd7 || a_mmc !== 16'd0 || b_mmc !== 3'd0 ||
             o_locked !== 2'b11 || o_error !== 2'b00) begin
            errors++;
            $display("FAIL idle_hold got mc=%0d/%0d mmc=%0d/%0d lck=%b err=%b exp 10/7 0/0 11 00",
                     a_mc, b_mc, a_mmc, b_mmc, o_locked, o_error);
         end
      end
   endtask

   task automatic test_clear_mid();
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      drive(1'b1, 8'h99, 1'b0, 1'b0);
      checks++;
      if (o_error !== 2'b11 || a_mmc !== 16'd2 || a_mc !== 16'd10) begin
         errors++;
         $display("FAIL pre_clear got err=%b mmc=%0d mc=%0d exp 11 2 10", o_error, a_mmc, a_mc);
      end
      drive(1'b1, 8'hA5, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_ready[k] !== 1'b0 || o_locked[k] !== 1'b0 || o_error[k] !== 1'b0 ||
             got_bad(k) !== 8'h00 || got_mc(k) !== 16'd0 || got_mmc(k) !== 16'd0) begin
            errors++;
            $display("FAIL clear_mid[%0d] got rdy=%b lck=%b err=%b bad=%h mc=%0d mmc=%0d exp all 0",
                     k, o_ready[k], o_locked[k], o_error[k], got_bad(k), got_mc(k), got_mmc(k));
         end
      end
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++;
      if (o_ready !== 2'b11 || a_mc !== 16'd0 || o_locked !== 2'b00) begin
         errors++;
         $display("FAIL not_ready_after_clear got rdy=%b mc=%0d lck=%b exp 11 0 00", o_ready, a_mc, o_locked);
      end
      drive(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++;
      if (a_mc !== 16'd1 || o_locked !== 2'b10) begin
         errors++;
         $display("FAIL first_accept got mc=%0d lck=%b exp 1 10", a_mc, o_locked);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 9) < 7),
               ($urandom_range(0, 3) != 0) ? 8'hA5 : 8'($urandom),
               1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 63) == 0));
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ready[k] !== m_ready || o_locked[k] !== m_locked[k] || o_error[k] !== m_error[k] ||
                got_bad(k) !== m_bad[k] || got_mc(k) !== exp_count(m_matches[k], m_cmax[k]) ||
                got_mmc(k) !== exp_count(m_mism[k], m_cmax[k])) begin
               errors++;
               $display("FAIL random[%0d] cyc %0d got rdy=%b lck=%b err=%b bad=%h mc=%0d mmc=%0d exp %b %b %b %h %0d %0d",
                        k, i, o_ready[k], o_locked[k], o_error[k], got_bad(k), got_mc(k), got_mmc(k),
                        m_ready, m_locked[k], m_error[k], m_bad[k],
                        exp_count(m_matches[k], m_cmax[k]), exp_count(m_mism[k], m_cmax[k]));
            end
         end
      end
   endtask

   initial begin
      m_ready = 1'b0;
      test_reset();
      test_lock();
      test_error_capture();
      test_rearm();
      test_saturation();
      test_clear_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got no finish exp finish");
      $fatal(1, "timeout");
   end

endmodule
